// File: rtl/usb_tx_pkt_arbiter_pkg.sv
// Shared types and helpers for the endpoint tx packet arbiter.
// Mailbox storage is accounted in 16-byte lines out of a 256-line pool.
package usb_tx_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    CLOSE
  } state_e;

  localparam int unsigned LINE_BYTES  = 16;
  localparam int unsigned TOTAL_LINES = 256;

  // A length that is an exact multiple of a line still occupies one extra line.
  function automatic logic [8:0] lines_of(input logic [11:0] len);
    return 9'(len / 12'(LINE_BYTES)) + 9'd1;
  endfunction

endpackage

// File: rtl/usb_tx_pkt_arbiter_if.sv
// Producer-side packet channel: first-word-fall-through packet with pop/done feedback.
// master = packet producer, slave = arbiter.
interface usb_tx_pkt_arbiter_if;
  logic        req;
  logic [11:0] len;
  logic [7:0]  data;
  logic        pop;
  logic        done;
  logic        err;

  modport master (output req, len, data, input  pop, done, err);
  modport slave  (input  req, len, data, output pop, done, err);
endinterface

// File: rtl/usb_tx_pkt_arbiter_line_fifo.sv
// Small FIFO of per-packet line costs queued in the mailbox.
// Head is kept in a register so the retire path sees a flop output.
module tx_line_fifo
  import usb_tx_pkt_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q, rd_d;
  logic [WIDTH-1:0] head_q, head_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Forward the pushed word when it lands in the slot that becomes the head.
  always_comb begin
    rd_d   = pop_i ? ptr_inc(rd_q) : rd_q;
    head_d = (push_i && (wr_q == rd_d)) ? push_data_i : mem_q[rd_d];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= ptr_inc(wr_q);
      end
      rd_q   <= rd_d;
      head_q <= head_d;
    end
  end

  assign head_o = head_q;

endmodule

// File: rtl/usb_tx_pkt_arbiter.sv
// Round-robin packet arbiter feeding one endpoint's tx mailbox from two producers,
// with slot/line occupancy tracking driven by the SIE tx handshake.
module usb_tx_pkt_arbiter
  import usb_tx_pkt_pkg::*;
#(
  parameter int unsigned P_ENDPOINT     = 1,
  parameter int unsigned MAX_PACKET_NUM = 8,
  parameter int unsigned P_MAX_PKT_LEN  = 512
) (
  input  logic                  clk,
  input  logic                  resetn,
  usb_tx_pkt_arbiter_if.slave   req0,
  usb_tx_pkt_arbiter_if.slave   req1,
  output logic [7:0]            m_tdata,
  output logic [11:0]           m_tlen,
  output logic                  m_tvalid,
  input  logic [3:0]            usb_endpt,
  input  logic                  usb_txact,
  input  logic                  usb_txpktfin,
  output logic [3:0]            pkt_pending,
  output logic [8:0]            lines_free
);

  state_e      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [11:0] tlen_q, tlen_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        owner_q, owner_d;
  logic        rr_q, rr_d;
  logic        wait_v_q, wait_v_d;
  logic        wait_id_q, wait_id_d;
  logic [3:0]  pend_q, pend_d;
  logic [8:0]  free_q, free_d;
  logic        act_q, fin_q, fin_d;

  logic        cand;
  logic [11:0] cand_len;
  logic        pop0, pop1, done0, done1, err0, err1;
  logic        push, active, fall, success;
  logic [5:0]  head_lines;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tlen_d    = tlen_q;
    tdata_d   = tdata_q;
    tvalid_d  = 1'b0;
    owner_d   = owner_q;
    rr_d      = rr_q;
    wait_v_d  = wait_v_q;
    wait_id_d = wait_id_q;
    cand      = 1'b0;
    cand_len  = '0;
    pop0      = 1'b0;
    pop1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    err0      = 1'b0;
    err1      = 1'b0;
    push      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0.req || req1.req) begin
          // A candidate stalled on mailbox space keeps its turn until served.
          if (wait_v_q && (wait_id_q ? req1.req : req0.req)) cand = wait_id_q;
          else if (req0.req && req1.req)                    cand = ~rr_q;
          else                                              cand = req1.req;
          cand_len = cand ? req1.len : req0.len;
          if ((cand_len == '0) || (cand_len > 12'(P_MAX_PKT_LEN))) begin
            done0    = ~cand;
            err0     = ~cand;
            done1    = cand;
            err1     = cand;
            rr_d     = cand;
            wait_v_d = 1'b0;
          end else if ((pend_q < 4'(MAX_PACKET_NUM)) && (free_q >= lines_of(cand_len))) begin
            tlen_d   = cand_len;
            cnt_d    = cand_len;
            owner_d  = cand;
            rr_d     = cand;
            wait_v_d = 1'b0;
            state_d  = STREAM;
          end else begin
            wait_v_d  = 1'b1;
            wait_id_d = cand;
          end
        end
      end
      STREAM: begin
        // One trailing cycle with the counter at zero lets the last byte show on m_tvalid.
        if (cnt_q != '0) begin
          pop0     = ~owner_q;
          pop1     = owner_q;
          tvalid_d = 1'b1;
          tdata_d  = owner_q ? req1.data : req0.data;
          cnt_d    = cnt_q - 12'd1;
        end else begin
          state_d = CLOSE;
        end
      end
      CLOSE: begin
        push    = 1'b1;
        done0   = ~owner_q;
        done1   = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign active  = (usb_endpt == 4'(P_ENDPOINT)) && usb_txact && (pend_q != '0);
  assign fall    = act_q && !active;
  assign success = fall && fin_q;
  assign fin_d   = fall ? 1'b0 : (fin_q | (active & usb_txpktfin));
  assign pend_d  = pend_q + {3'b0, push} - {3'b0, success};
  assign free_d  = free_q - (push ? lines_of(tlen_q) : 9'd0)
                 + (success ? {3'b0, head_lines} : 9'd0);

  tx_line_fifo #(
    .DEPTH (MAX_PACKET_NUM),
    .WIDTH (6)
  ) u_line_fifo (
    .clk_i       (clk),
    .rst_ni      (resetn),
    .push_i      (push),
    .push_data_i (6'(lines_of(tlen_q))),
    .pop_i       (success),
    .head_o      (head_lines)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tlen_q    <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      owner_q   <= 1'b0;
      rr_q      <= 1'b1;
      wait_v_q  <= 1'b0;
      wait_id_q <= 1'b0;
      pend_q    <= '0;
      free_q    <= 9'(TOTAL_LINES);
      act_q     <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tlen_q    <= tlen_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      wait_v_q  <= wait_v_d;
      wait_id_q <= wait_id_d;
      pend_q    <= pend_d;
      free_q    <= free_d;
      act_q     <= active;
      fin_q     <= fin_d;
    end
  end

  assign req0.pop    = pop0;
  assign req1.pop    = pop1;
  assign req0.done   = done0;
  assign req1.done   = done1;
  assign req0.err    = err0;
  assign req1.err    = err1;
  assign m_tdata     = tdata_q;
  assign m_tlen      = tlen_q;
  assign m_tvalid    = tvalid_q;
  assign pkt_pending = pend_q;
  assign lines_free  = free_q;

endmodule

// File: tb/tb_usb_tx_pkt_arbiter.sv
// Bench for usb_tx_pkt_arbiter: packet-timeline reference model plus directed and random traffic.
module tb_usb_tx_pkt_arbiter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  usb_tx_pkt_arbiter_if r0 ();
  usb_tx_pkt_arbiter_if r1 ();

  logic [7:0]  m_tdata;
  logic [11:0] m_tlen;
  logic        m_tvalid;
  logic [3:0]  usb_endpt = '0;
  logic        usb_txact = 1'b0;
  logic        usb_txpktfin = 1'b0;
  logic [3:0]  pkt_pending;
  logic [8:0]  lines_free;

  usb_tx_pkt_arbiter #(
    .P_ENDPOINT     (1),
    .MAX_PACKET_NUM (8),
    .P_MAX_PKT_LEN  (512)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req0         (r0),
    .req1         (r1),
    .m_tdata      (m_tdata),
    .m_tlen       (m_tlen),
    .m_tvalid     (m_tvalid),
    .usb_endpt    (usb_endpt),
    .usb_txact    (usb_txact),
    .usb_txpktfin (usb_txpktfin),
    .pkt_pending  (pkt_pending),
    .lines_free   (lines_free)
  );

  typedef struct {
    int len;
    int base;
  } pkt_t;

  // Producer queues and mailbox contents (line cost per queued packet).
  pkt_t pq0[$];
  pkt_t pq1[$];
  int   mbq[$];
  int   bidx[2];
  // Current grant as a timeline: grant cycle, length, owner, byte base.
  int   busy, g_cyc, g_len, g_own, g_base;
  int   rr, wait_v, wait_id, exp_tlen;
  int   act_prev, fin_l, cyc;
  int   nx_endpt, nx_txact, nx_fin;
  int   win_left, win_ep, win_fin;
  int   passes, total;
  int   order[$];
  int   prev_pop0, prev_pop1, tv_cnt, err_cnt, pop_cnt;

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act == exp_v) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
  endtask

  function automatic int qsize(input int p);
    return (p == 0) ? pq0.size() : pq1.size();
  endfunction

  function automatic pkt_t qhead(input int p);
    return (p == 0) ? pq0[0] : pq1[0];
  endfunction

  task automatic enqueue(input int p, input int len, input int base);
    pkt_t k;
    k.len = len;
    k.base = base;
    if (p == 0) pq0.push_back(k);
    else        pq1.push_back(k);
  endtask

  task automatic drive_inputs();
    pkt_t h;
    r0.req = 1'b0; r0.len = '0; r0.data = '0;
    r1.req = 1'b0; r1.len = '0; r1.data = '0;
    if (pq0.size() > 0) begin
      h = pq0[0];
      r0.req = 1'b1; r0.len = 12'(h.len); r0.data = 8'(h.base + bidx[0]);
    end
    if (pq1.size() > 0) begin
      h = pq1[0];
      r1.req = 1'b1; r1.len = 12'(h.len); r1.data = 8'(h.base + bidx[1]);
    end
    usb_endpt    = 4'(nx_endpt);
    usb_txact    = (nx_txact != 0);
    usb_txpktfin = (nx_fin != 0);
  endtask

  task automatic model_clear();
    pq0.delete(); pq1.delete(); mbq.delete();
    bidx[0] = 0; bidx[1] = 0;
    busy = 0; rr = 1; wait_v = 0; wait_id = 0; exp_tlen = 0;
    act_prev = 0; fin_l = 0;
    nx_endpt = 0; nx_txact = 0; nx_fin = 0; win_left = 0;
  endtask

  // One clock: drive after the edge, compare at the falling edge, then advance the model.
  task automatic cycle();
    int e_pop[2], e_done[2], e_err[2];
    int e_tv, e_td, pend, free, cand, off, act, fall, succ, closing, new_tlen;
    pkt_t h;
    @(posedge clk); #1;
    drive_inputs();
    @(negedge clk);
    e_pop[0] = 0; e_pop[1] = 0; e_done[0] = 0; e_done[1] = 0; e_err[0] = 0; e_err[1] = 0;
    e_tv = 0; e_td = 0; closing = 0; new_tlen = -1; off = 0;
    pend = mbq.size();
    free = 256;
    foreach (mbq[i]) free -= mbq[i];
    if (busy != 0) begin
      off = cyc - g_cyc;
      if (off >= 1 && off <= g_len) e_pop[g_own] = 1;
      if (off >= 2 && off <= g_len + 1) begin
        e_tv = 1;
        e_td = (g_base + off - 2) % 256;
      end
      if (off == g_len + 2) begin
        e_done[g_own] = 1;
        closing = 1;
      end
    end else if (qsize(0) > 0 || qsize(1) > 0) begin
      if (wait_v != 0 && qsize(wait_id) > 0) cand = wait_id;
      else if (qsize(0) > 0 && qsize(1) > 0) cand = 1 - rr;
      else cand = (qsize(1) > 0) ? 1 : 0;
      h = qhead(cand);
      if (h.len == 0 || h.len > 512) begin
        e_done[cand] = 1; e_err[cand] = 1; rr = cand; wait_v = 0;
      end else if (pend < 8 && free >= h.len / 16 + 1) begin
        busy = 1; g_cyc = cyc; g_len = h.len; g_own = cand; g_base = h.base;
        rr = cand; wait_v = 0; new_tlen = h.len;
      end else begin
        wait_v = 1; wait_id = cand;
      end
    end
    act  = (nx_endpt == 1 && nx_txact != 0 && pend != 0) ? 1 : 0;
    fall = (act_prev != 0 && act == 0) ? 1 : 0;
    succ = (fall != 0 && fin_l != 0) ? 1 : 0;

    chk("pop0", int'(r0.pop), e_pop[0]);
    chk("pop1", int'(r1.pop), e_pop[1]);
    chk("done0", int'(r0.done), e_done[0]);
    chk("done1", int'(r1.done), e_done[1]);
    chk("err0", int'(r0.err), e_err[0]);
    chk("err1", int'(r1.err), e_err[1]);
    chk("m_tvalid", int'(m_tvalid), e_tv);
    if (e_tv != 0) chk("m_tdata", int'(m_tdata), e_td);
    chk("m_tlen", int'(m_tlen), exp_tlen);
    chk("pkt_pending", int'(pkt_pending), pend);
    chk("lines_free", int'(lines_free), free);

    if (r0.pop && prev_pop0 == 0) order.push_back(0);
    if (r1.pop && prev_pop1 == 0) order.push_back(1);
    prev_pop0 = int'(r0.pop);
    prev_pop1 = int'(r1.pop);
    tv_cnt  += int'(m_tvalid);
    err_cnt += int'(r0.err) + int'(r1.err);
    pop_cnt += int'(r0.pop) + int'(r1.pop);

    if (new_tlen >= 0) exp_tlen = new_tlen;
    if (succ != 0) void'(mbq.pop_front());
    if (closing != 0) begin
      mbq.push_back(g_len / 16 + 1);
      busy = 0;
    end
    fin_l = (fall != 0) ? 0 : ((fin_l != 0 || (act != 0 && nx_fin != 0)) ? 1 : 0);
    act_prev = act;
    for (int p = 0; p < 2; p++) begin
      if (e_pop[p] != 0) bidx[p]++;
      if (e_done[p] != 0) begin
        if (p == 0) void'(pq0.pop_front());
        else        void'(pq1.pop_front());
        bidx[p] = 0;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    chk("rst_tvalid", int'(m_tvalid), 0);
    chk("rst_pop0", int'(r0.pop), 0);
    chk("rst_pop1", int'(r1.pop), 0);
    chk("rst_pending", int'(pkt_pending), 0);
    chk("rst_lines", int'(lines_free), 256);
    chk("rst_tlen", int'(m_tlen), 0);
    model_clear();
    drive_inputs();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until_idle(input string nm, input int budget);
    int left;
    left = budget;
    while ((busy != 0 || pq0.size() > 0 || pq1.size() > 0) && left > 0) begin
      usb_step(1);
      cycle();
      left--;
    end
    if (left == 0) chk({nm, "_timeout"}, 1, 0);
    cycle();
  endtask

  // Windows are separated by at least one idle cycle; endpoint 2 windows must be ignored.
  task automatic usb_step(input int allow);
    if (win_left > 0) begin
      nx_endpt = win_ep; nx_txact = 1;
      nx_fin = (win_left == 1 && win_fin != 0) ? 1 : 0;
      win_left--;
    end else begin
      nx_txact = 0; nx_fin = 0;
      if (allow != 0 && $urandom_range(0, 7) == 0) begin
        win_left = $urandom_range(1, 4);
        win_ep   = ($urandom_range(0, 3) == 0) ? 2 : 1;
        win_fin  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      end
    end
  endtask

  task automatic usb_window(input int ep, input int len, input int fin);
    for (int i = 0; i < len; i++) begin
      nx_endpt = ep; nx_txact = 1; nx_fin = (fin != 0 && i == len - 1) ? 1 : 0;
      cycle();
    end
    nx_txact = 0; nx_fin = 0;
    run(3);
  endtask

  function automatic int rand_len();
    int r;
    r = $urandom_range(0, 39);
    case (r)
      0: return 0;
      1: return 600;
      2: return 512;
      3: return 16;
      4: return 32;
      default: return $urandom_range(1, 40);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int left;
    passes = 0; total = 0; cyc = 0;
    prev_pop0 = 0; prev_pop1 = 0; tv_cnt = 0; err_cnt = 0; pop_cnt = 0;
    model_clear();
    drive_inputs();
    repeat (2) @(negedge clk);
    do_reset();

    // Single 5-byte packet from req0.
    enqueue(0, 5, 8'hA0);
    tv_cnt = 0;
    run_until_idle("t1", 60);
    chk("t1_tvalid_cycles", tv_cnt, 5);
    chk("t1_pending", int'(pkt_pending), 1);
    chk("t1_lines", int'(lines_free), 255);
    chk("t1_tlen", int'(m_tlen), 5);

    // Both requesting from reset: req0, req1, then req0 again.
    do_reset();
    order.delete();
    enqueue(0, 3, 8'h10);
    enqueue(1, 4, 8'h20);
    enqueue(0, 2, 8'h30);
    run_until_idle("t2", 80);
    chk("t2_grants", order.size(), 3);
    if (order.size() == 3) begin
      chk("t2_first", order[0], 0);
      chk("t2_second", order[1], 1);
      chk("t2_third", order[2], 0);
    end

    // Fill the mailbox with eight 16-byte packets; the ninth must wait for a retire.
    do_reset();
    for (int i = 0; i < 9; i++) enqueue(0, 16, 16 * i);
    run(200);
    chk("t3_pending_full", int'(pkt_pending), 8);
    chk("t3_lines_full", int'(lines_free), 240);
    chk("t3_ninth_held", int'(r0.pop), 0);
    chk("t3_model_queued", pq0.size(), 1);
    usb_window(1, 2, 1);
    run(30);
    chk("t3_ninth_sent", pq0.size(), 0);
    chk("t3_pending_after", int'(pkt_pending), 8);
    chk("t3_lines_after", int'(lines_free), 240);

    // NAK window changes nothing; a window with pktfin retires one packet.
    usb_window(1, 3, 0);
    chk("t4_nak_pending", int'(pkt_pending), 8);
    chk("t4_nak_lines", int'(lines_free), 240);
    usb_window(2, 2, 1);
    chk("t4_other_ep_pending", int'(pkt_pending), 8);
    usb_window(1, 2, 1);
    chk("t4_ok_pending", int'(pkt_pending), 7);
    chk("t4_ok_lines", int'(lines_free), 242);

    // Illegal lengths are rejected without popping or streaming.
    enqueue(1, 0, 0);
    enqueue(1, 600, 0);
    err_cnt = 0; pop_cnt = 0; tv_cnt = 0;
    run(6);
    chk("t5_errs", err_cnt, 2);
    chk("t5_pops", pop_cnt, 0);
    chk("t5_tvalid", tv_cnt, 0);

    // Reset in the middle of a 10-byte packet, then a clean packet afterwards.
    do_reset();
    enqueue(0, 10, 8'h40);
    left = 40;
    while (bidx[0] < 2 && left > 0) begin
      cycle();
      left--;
    end
    if (left == 0) chk("t6_timeout", 1, 0);
    @(posedge clk); #2;
    chk("t6_pop_before_rst", int'(r0.pop), 1);
    do_reset();
    enqueue(0, 10, 8'h50);
    run_until_idle("t6", 40);
    chk("t6_pending", int'(pkt_pending), 1);
    chk("t6_tlen", int'(m_tlen), 10);

    // Random traffic from both producers with random SIE windows.
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      for (int p = 0; p < 2; p++)
        if (qsize(p) < 2 && $urandom_range(0, 7) == 0) enqueue(p, rand_len(), $urandom_range(0, 255));
      usb_step(1);
      cycle();
    end
    run_until_idle("drain", 6000);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
